// File: rtl/vic_wb_ctrl.sv
// Writeback buffer controller between a victim cache and memory.
// Dirty victims queue in a FIFO and share the memory port with D-cache loads.
module vic_wb_ctrl #(
  parameter int TAG_BITS = 10,
  parameter int SET_BITS = 3,
  parameter int WB_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fired_valid,
  input  logic                fired_dirty,
  input  logic [TAG_BITS-1:0] fired_tag,
  input  logic [SET_BITS-1:0] fired_set,
  input  logic [63:0]         fired_data,
  output logic                wb_full,
  output logic                wb_empty,
  input  logic                ld_req,
  input  logic [15:0]         ld_addr,
  output logic                ld_grant,
  output logic [3:0]          ld_tag,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [1:0]          mem_command,
  output logic [15:0]         mem_addr,
  output logic [63:0]         mem_data,
  input  logic [3:0]          mem_response
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    starve_q, starve_d;

  logic [15:0]   addrMem_q [WB_DEPTH];
  logic [63:0]   dataMem_q [WB_DEPTH];

  logic          flushing;
  logic          conflict;
  logic          enqueue;
  logic          accepted;
  logic          storeAcc;
  logic          loadAcc;
  logic [1:0]    command;
  logic [15:0]   firedAddr;
  logic [PW-1:0] offset;

  assign wb_full   = (count_q == DEPTH_C);
  assign wb_empty  = (count_q == '0);
  assign firedAddr = 16'({fired_tag, fired_set, 3'b000});
  assign enqueue   = fired_valid & fired_dirty & ~wb_full;
  assign accepted  = (mem_response != 4'd0);
  assign storeAcc  = (command == CMD_STORE) & accepted;
  assign loadAcc   = (command == CMD_LOAD) & accepted;

  // An entry is occupied when its distance from head is below the count.
  always_comb begin
    conflict = 1'b0;
    offset   = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      offset = PW'(i) - head_q;
      if ((CW'(offset) < count_q) && (addrMem_q[i][15:3] == ld_addr[15:3]))
        conflict = 1'b1;
    end
  end

  always_comb begin
    command = CMD_NONE;
    if (!wb_empty && (flushing || wb_full || conflict || (starve_q == 2'd3)))
      command = CMD_STORE;
    else if (ld_req && !flushing)
      command = CMD_LOAD;
    else if (!wb_empty)
      command = CMD_STORE;
  end

  always_comb begin
    mem_command = command;
    mem_addr    = 16'd0;
    mem_data    = 64'd0;
    ld_grant    = loadAcc;
    ld_tag      = loadAcc ? mem_response : 4'd0;
    if (command == CMD_STORE) begin
      mem_addr = addrMem_q[head_q];
      mem_data = dataMem_q[head_q];
    end else if (command == CMD_LOAD) begin
      mem_addr = ld_addr;
    end
  end

  always_comb begin
    head_d  = storeAcc ? head_q + PW'(1) : head_q;
    tail_d  = enqueue ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({enqueue, storeAcc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    starve_d = starve_q;
    if (wb_empty || storeAcc)
      starve_d = 2'd0;
    else if (loadAcc && (starve_q != 2'd3))
      starve_d = starve_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= 2'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge clock) begin
    if (enqueue) begin
      addrMem_q[tail_q] <= firedAddr;
      dataMem_q[tail_q] <= fired_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req && !wb_empty) state_d = FLUSH;
      FLUSH:   if (wb_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush request against an already empty buffer completes immediately.
  always_comb begin
    flushing   = (state_q == FLUSH);
    flush_done = wb_empty && ((state_q == FLUSH) || ((state_q == IDLE) && flush_req));
  end

endmodule

// File: tb/tb_vic_wb_ctrl.sv
// Bench for vic_wb_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the writeback buffer.
module tb_vic_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        fired_valid;
  logic        fired_dirty;
  logic [9:0]  fired_tag;
  logic [2:0]  fired_set;
  logic [63:0] fired_data;
  logic        wb_full;
  logic        wb_empty;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_grant;
  logic [3:0]  ld_tag;
  logic        flush_req;
  logic        flush_done;
  logic [1:0]  mem_command;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic [3:0]  mem_response;

  vic_wb_ctrl #(.TAG_BITS(10), .SET_BITS(3), .WB_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .fired_valid(fired_valid), .fired_dirty(fired_dirty), .fired_tag(fired_tag),
    .fired_set(fired_set), .fired_data(fired_data),
    .wb_full(wb_full), .wb_empty(wb_empty),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant), .ld_tag(ld_tag),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_response(mem_response)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit fv, input bit fd, input logic [9:0] tag,
                               input logic [2:0] set, input logic [63:0] data,
                               input bit lr, input logic [15:0] la, input bit fr,
                               input logic [3:0] resp);
    fired_valid  = fv;
    fired_dirty  = fd;
    fired_tag    = tag;
    fired_set    = set;
    fired_data   = data;
    ld_req       = lr;
    ld_addr      = la;
    flush_req    = fr;
    mem_response = resp;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Reference model: buffer contents as a queue, oldest first.
  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } entry_t;

  entry_t mq[$];
  int     mStarve = 0;
  bit     mFlushing = 1'b0;
  bit     modelValid = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      begin
        int          n;
        bit          hit;
        bit          forceStore;
        logic [1:0]  eCmd;
        logic [15:0] eAddr;
        logic [63:0] eData;
        bit          eGrant;
        bit          storeOk;
        bit          loadOk;
        entry_t      e;
        n = mq.size();
        if (modelValid) begin
          hit = 1'b0;
          foreach (mq[i]) if (mq[i].addr[15:3] == ld_addr[15:3]) hit = 1'b1;
          forceStore = mFlushing || (n == DEPTH) || hit || (mStarve == 3);
          if (n > 0 && forceStore)           eCmd = 2'd2;
          else if (ld_req && !mFlushing)     eCmd = 2'd1;
          else if (n > 0)                    eCmd = 2'd2;
          else                               eCmd = 2'd0;
          eAddr  = (eCmd == 2'd2) ? mq[0].addr : ((eCmd == 2'd1) ? ld_addr : 16'd0);
          eData  = (eCmd == 2'd2) ? mq[0].data : 64'd0;
          eGrant = (eCmd == 2'd1) && (mem_response != 4'd0);
          checkOutput("wb_full", 64'(wb_full), 64'(n == DEPTH));
          checkOutput("wb_empty", 64'(wb_empty), 64'(n == 0));
          checkOutput("mem_command", 64'(mem_command), 64'(eCmd));
          checkOutput("mem_addr", 64'(mem_addr), 64'(eAddr));
          checkOutput("mem_data", mem_data, eData);
          checkOutput("ld_grant", 64'(ld_grant), 64'(eGrant));
          checkOutput("ld_tag", 64'(ld_tag), eGrant ? 64'(mem_response) : 64'd0);
          checkOutput("flush_done", 64'(flush_done), 64'((n == 0) && (mFlushing || flush_req)));
          if (!reset) begin
            storeOk = (eCmd == 2'd2) && (mem_response != 4'd0);
            loadOk  = eGrant;
            if (n == 0 || storeOk)            mStarve = 0;
            else if (loadOk && mStarve < 3)   mStarve++;
            if (mFlushing) begin
              if (n == 0) mFlushing = 1'b0;
            end else if (flush_req && n > 0) begin
              mFlushing = 1'b1;
            end
            if (storeOk) void'(mq.pop_front());
            if (fired_valid && fired_dirty && n < DEPTH) begin
              e.addr = {fired_tag, fired_set, 3'b000};
              e.data = fired_data;
              mq.push_back(e);
            end
          end
        end
        if (reset) begin
          mq.delete();
          mStarve    = 0;
          mFlushing  = 1'b0;
          modelValid = 1'b1;
        end
      end
    end
  end

  localparam logic [1:0] LD = 2'd1;
  localparam logic [1:0] ST = 2'd2;

  initial begin
    logic [1:0] pattern [5];
    pattern[0] = LD; pattern[1] = LD; pattern[2] = LD; pattern[3] = ST; pattern[4] = LD;
    reset = 1'b1;
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    #2;
    checkOutput("reset wb_empty", 64'(wb_empty), 64'd1);
    checkOutput("reset wb_full", 64'(wb_full), 64'd0);
    checkOutput("reset mem_command", 64'(mem_command), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset mem_data", mem_data, 64'd0);
    checkOutput("reset ld_tag", 64'(ld_tag), 64'd0);
    checkOutput("reset flush_done", 64'(flush_done), 64'd0);
    stepCycle();

    // Single dirty victim drains with one accepted STORE.
    applyStimulus(1, 1, 10'h2AB, 3'd2, 64'hDEAD, 0, 16'd0, 0, 4'd5);
    stepCycle();
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd5);
    #2;
    checkOutput("single store cmd", 64'(mem_command), 64'(ST));
    checkOutput("single store addr", 64'(mem_addr), 64'hAAD0);
    checkOutput("single store data", mem_data, 64'hDEAD);
    stepCycle();
    #2;
    checkOutput("single drained", 64'(wb_empty), 64'd1);

    // Fill to full with rejected stores; fifth victim is refused.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 10'(10'h101 + i), 3'd1, 64'(i + 100), 0, 16'd0, 0, 4'd0);
      stepCycle();
    end
    applyStimulus(1, 1, 10'h1FF, 3'd7, 64'd999, 1, 16'h0008, 0, 4'd0);
    #2;
    checkOutput("full flag", 64'(wb_full), 64'd1);
    checkOutput("full forces store", 64'(mem_command), 64'(ST));
    stepCycle();
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd1);
    #2;
    checkOutput("fifth refused", 64'(wb_full), 64'd1);
    checkOutput("head still first", 64'(mem_addr), 64'h4048);
    repeat (4) stepCycle();
    #2;
    checkOutput("full drained", 64'(wb_empty), 64'd1);

    // Load conflicting with a buffered line waits for that line's STORE.
    applyStimulus(1, 1, 10'h2AB, 3'd2, 64'h55, 0, 16'd0, 0, 4'd0);
    stepCycle();
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 1, 16'hAAD4, 0, 4'd3);
    #2;
    checkOutput("conflict store", 64'(mem_command), 64'(ST));
    checkOutput("conflict store addr", 64'(mem_addr), 64'hAAD0);
    checkOutput("conflict no grant", 64'(ld_grant), 64'd0);
    stepCycle();
    #2;
    checkOutput("conflict then load", 64'(mem_command), 64'(LD));
    checkOutput("conflict ld_grant", 64'(ld_grant), 64'd1);
    checkOutput("conflict ld_tag", 64'(ld_tag), 64'd3);
    checkOutput("conflict load addr", 64'(mem_addr), 64'hAAD4);
    stepCycle();

    // Starvation: three LOADs then a forced STORE.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 10'(10'h300 + i), 3'd0, 64'(i), 0, 16'd0, 0, 4'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 1, 16'h0100, 0, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #2;
      checkOutput("starve sequence", 64'(mem_command), 64'(pattern[i]));
      stepCycle();
    end
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd1);
    repeat (3) stepCycle();

    // Flush: three STOREs, no LOAD, done pulse as count reaches zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 10'(10'h010 + i), 3'd3, 64'(i), 0, 16'd0, 0, 4'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 1, 4'd0);
    #2;
    checkOutput("flush start no done", 64'(flush_done), 64'd0);
    stepCycle();
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 1, 16'h0100, 0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("flush store", 64'(mem_command), 64'(ST));
      stepCycle();
    end
    #2;
    checkOutput("flush done pulse", 64'(flush_done), 64'd1);
    checkOutput("flush no load", 64'(mem_command), 64'd0);
    stepCycle();
    #2;
    checkOutput("flush done cleared", 64'(flush_done), 64'd0);
    checkOutput("idle load resumes", 64'(mem_command), 64'(LD));
    stepCycle();

    // Flush request on an empty buffer completes in the same cycle.
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 1, 4'd0);
    #2;
    checkOutput("empty flush done", 64'(flush_done), 64'd1);
    stepCycle();
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd0);
    #2;
    checkOutput("empty flush single", 64'(flush_done), 64'd0);

    // Reset during a STORE discards the buffer.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 10'(10'h050 + i), 3'd4, 64'(i), 0, 16'd0, 0, 4'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd1);
    reset = 1'b1;
    #2;
    checkOutput("store under reset", 64'(mem_command), 64'(ST));
    stepCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd0);
    #2;
    checkOutput("post reset empty", 64'(wb_empty), 64'd1);
    checkOutput("post reset cmd", 64'(mem_command), 64'd0);
    stepCycle();

    // Random traffic with a small address pool so conflicts are common.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                    10'($urandom_range(0, 7)), 3'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 9) < 6,
                    {10'($urandom_range(0, 7)), 3'($urandom), 3'($urandom)},
                    $urandom_range(0, 19) == 0,
                    ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15)));
      reset = ($urandom_range(0, 99) == 0);
      stepCycle();
    end
    reset = 1'b0;
    applyStimulus(0, 0, 10'd0, 3'd0, 64'd0, 0, 16'd0, 0, 4'd1);
    repeat (6) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
